// File: rtl/argmax_classifier.sv
// Serial argmax over a 10-score frame from the fully connected layer.
// Optional ARGMAX_MARGIN_EN adds runner-up tracking and the out_margin port.
module argmax_classifier #(
    parameter int bitwidth = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [bitwidth-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_class,
    output logic signed [bitwidth-1:0] out_score
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [bitwidth-1:0]        out_margin
`endif
);

    typedef enum logic {SCAN, HOLD} state_t;

    localparam logic signed [bitwidth-1:0] most_neg = {1'b1, {(bitwidth-1){1'b0}}};

    state_t                     state;
    logic [3:0]                 beat;
    logic signed [bitwidth-1:0] run_max;
    logic [3:0]                 run_idx;
    logic signed [bitwidth-1:0] nxt_max;
    logic [3:0]                 nxt_idx;
    logic                       accept;

`ifdef ARGMAX_MARGIN_EN
    logic signed [bitwidth-1:0] run_second;
    logic signed [bitwidth-1:0] nxt_second;
    logic [bitwidth:0]          diff;
`endif

    assign accept = in_valid && (state == SCAN);

    // Candidate update for the current beat; only committed when a beat is accepted.
    always_comb begin
        nxt_max = run_max;
        nxt_idx = run_idx;
`ifdef ARGMAX_MARGIN_EN
        nxt_second = run_second;
`endif
        if (beat == 4'd0) begin
            nxt_max = in_data;
            nxt_idx = 4'd0;
`ifdef ARGMAX_MARGIN_EN
            nxt_second = most_neg;
`endif
        end else if (in_data > run_max) begin
            nxt_max = in_data;
            nxt_idx = beat;
`ifdef ARGMAX_MARGIN_EN
            nxt_second = run_max;
`endif
        end
`ifdef ARGMAX_MARGIN_EN
        else if (in_data > run_second) begin
            nxt_second = in_data;
        end
`endif
    end

`ifdef ARGMAX_MARGIN_EN
    // Sign-extended difference; max >= runner-up keeps it in 0..2^bitwidth-1.
    assign diff = {nxt_max[bitwidth-1], nxt_max} - {nxt_second[bitwidth-1], nxt_second};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            beat      <= 4'd0;
            run_max   <= '0;
            run_idx   <= 4'd0;
            out_class <= 4'd0;
            out_score <= '0;
`ifdef ARGMAX_MARGIN_EN
            run_second <= '0;
            out_margin <= '0;
`endif
        end else begin
            case (state)
                SCAN: begin
                    if (accept) begin
                        run_max <= nxt_max;
                        run_idx <= nxt_idx;
`ifdef ARGMAX_MARGIN_EN
                        run_second <= nxt_second;
`endif
                        if (beat == 4'd9) begin
                            beat      <= 4'd0;
                            out_class <= nxt_idx;
                            out_score <= nxt_max;
`ifdef ARGMAX_MARGIN_EN
                            out_margin <= diff[bitwidth-1:0];
`endif
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            beat <= beat + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= SCAN;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= SCAN;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier; margin checks are
// compiled in only when ARGMAX_MARGIN_EN is defined.
module tb_argmax_classifier;

    localparam int bitwidth = 32;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       in_valid = 1'b0;
    logic                       out_ready = 1'b0;
    logic signed [bitwidth-1:0] in_data = '0;
    logic                       in_ready;
    logic                       out_valid;
    logic [3:0]                 out_class;
    logic signed [bitwidth-1:0] out_score;
`ifdef ARGMAX_MARGIN_EN
    logic [bitwidth-1:0]        out_margin;
`endif

    int compared = 0;
    int mismatched = 0;
    logic signed [bitwidth-1:0] frame [10];

    argmax_classifier #(.bitwidth(bitwidth)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
`ifdef ARGMAX_MARGIN_EN
        ,
        .out_margin(out_margin)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [3:0] cls, input logic [31:0] score,
                               input logic [31:0] margin);
        checkOutput({tag, "_class"}, {28'd0, out_class}, {28'd0, cls});
        checkOutput({tag, "_score"}, out_score, score);
`ifdef ARGMAX_MARGIN_EN
        checkOutput({tag, "_margin"}, out_margin, margin);
`else
        if (margin == 32'hDEAD_BEEF) $display("[TB] margin %0h", margin);
`endif
    endtask

    // Sends frame[0..n-1]; with gaps, idle cycles are inserted before beats.
    task automatic applyStimulus(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                repeat (idle) begin
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput("in_ready_beat", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = frame[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 32'h0BAD_0BAD;
            if (n == 10 && i == 8) checkOutput("out_valid_early", {31'd0, out_valid}, 32'd0);
            if (n == 10 && i == 9) checkOutput("out_valid_latency", {31'd0, out_valid}, 32'd1);
        end
    endtask

    // Junk on in_valid during the release cycle must not be accepted.
    task automatic releaseResult();
        in_valid  = 1'b1;
        in_data   = 32'h7FFF_FFFF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkResult("reset", 4'd0, 32'd0, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) frame[i] = i;
        applyStimulus(10, 1'b0);
        checkResult("ramp", 4'd9, 32'd9, 32'd1);
        releaseResult();

        for (int i = 0; i < 10; i++) frame[i] = -5;
        applyStimulus(10, 1'b0);
        checkResult("all_equal", 4'd0, 32'hFFFF_FFFB, 32'd0);
        releaseResult();

        for (int i = 0; i < 10; i++) frame[i] = -100;
        frame[3] = 16384;
        frame[7] = 16384;
        applyStimulus(10, 1'b0);
        checkResult("tie", 4'd3, 32'd16384, 32'd0);
        releaseResult();

        for (int i = 0; i < 10; i++) frame[i] = 32'h8000_0000;
        frame[4] = 32'h7FFF_FFFF;
        applyStimulus(10, 1'b0);
        checkResult("extremes", 4'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        releaseResult();

        frame[0] = 5;   frame[1] = -3; frame[2] = 40; frame[3] = 7;  frame[4] = 9;
        frame[5] = 0;   frame[6] = -20; frame[7] = 31; frame[8] = 3; frame[9] = 8;
        applyStimulus(10, 1'b1);
        checkResult("gaps", 4'd2, 32'd40, 32'd9);
        in_valid = 1'b1;
        in_data  = 32'h7FFF_0000;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkResult("hold", 4'd2, 32'd40, 32'd9);
        end
        releaseResult();

        for (int i = 0; i < 10; i++) frame[i] = 0;
        frame[1] = 1000;
        applyStimulus(7, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midframe_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midframe_rst_in_ready", {31'd0, in_ready}, 32'd1);
        frame[0] = 1; frame[1] = 2; frame[2] = 50; frame[3] = 3; frame[4] = 4;
        frame[5] = 5; frame[6] = 6; frame[7] = 7;  frame[8] = 8; frame[9] = 9;
        applyStimulus(10, 1'b0);
        checkResult("after_abort", 4'd2, 32'd50, 32'd41);

        rst = 1'b1;
        #1;
        checkOutput("hold_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("hold_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkResult("hold_rst", 4'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
